// File: rtl/cla_add_scheduler.sv
// Two-requester scheduler that time-shares one 4-bit carry-lookahead adder,
// summing wide operands one nibble per cycle with the carry chained through a register.

module cla_nibble (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bit
         assign p[gi]   = a[gi] ^ b[gi];
         assign g[gi]   = a[gi] & b[gi];
         assign sum[gi] = p[gi] ^ c[gi];
      end
   endgenerate

   // Every carry is flattened so that none depends on a lower carry.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
   assign cout = c[4];
endmodule

module cla_add_scheduler #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic [4*NIBBLES-1:0]   req0_a,
   input  logic [4*NIBBLES-1:0]   req0_b,
   input  logic                   req0_cin,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic [4*NIBBLES-1:0]   req1_a,
   input  logic [4*NIBBLES-1:0]   req1_b,
   input  logic                   req1_cin,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [4*NIBBLES-1:0]   res_sum,
   output logic                   res_cout,
   output logic                   res_id,
   output logic                   busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          id_reg;
   logic          carry_reg;
   logic [KW-1:0] k_reg;
   logic          ptr_reg;
   logic [W-1:0]  res_sum_reg;
   logic          res_cout_reg;
   logic          res_id_reg;
   logic          res_valid_reg;

   logic          grant0;
   logic          grant1;
   logic          last_nibble;
   logic [3:0]    nib_a;
   logic [3:0]    nib_b;
   logic [3:0]    nib_sum;
   logic          nib_cout;

   assign last_nibble = (k_reg == KW'(NIBBLES - 1));
   assign nib_a       = a_reg[4*k_reg +: 4];
   assign nib_b       = b_reg[4*k_reg +: 4];

   cla_nibble u_nibble (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry_reg),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant0 || grant1) state_next = ADD;
         ADD:     if (last_nibble)      state_next = DONE;
         DONE:    if (res_ready)        state_next = IDLE;
         default:                       state_next = IDLE;
      endcase
   end

   // Output decode: ready is masked by rst so it reads 0 while reset is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      busy   = 1'b1;
      if (state == IDLE) begin
         busy   = 1'b0;
         grant0 = !rst && req0_valid && (!req1_valid || !ptr_reg);
         grant1 = !rst && req1_valid && (!req0_valid ||  ptr_reg);
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= 1'b0;
         carry_reg     <= 1'b0;
         k_reg         <= '0;
         ptr_reg       <= 1'b0;
         res_sum_reg   <= '0;
         res_cout_reg  <= 1'b0;
         res_id_reg    <= 1'b0;
         res_valid_reg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  a_reg     <= grant1 ? req1_a   : req0_a;
                  b_reg     <= grant1 ? req1_b   : req0_b;
                  carry_reg <= grant1 ? req1_cin : req0_cin;
                  id_reg    <= grant1;
                  k_reg     <= '0;
                  // Priority passes to whichever requester was not served.
                  ptr_reg   <= grant0;
               end
            end
            ADD: begin
               res_sum_reg[4*k_reg +: 4] <= nib_sum;
               carry_reg                 <= nib_cout;
               k_reg                     <= k_reg + KW'(1);
               if (last_nibble) begin
                  res_cout_reg  <= nib_cout;
                  res_id_reg    <= id_reg;
                  res_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (res_ready) res_valid_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign res_valid = res_valid_reg;
   assign res_sum   = res_sum_reg;
   assign res_cout  = res_cout_reg;
   assign res_id    = res_id_reg;
endmodule

// File: tb/tb_cla_add_scheduler.sv
// Directed bench for cla_add_scheduler: a NIBBLES=4 instance for the main scenarios
// and a NIBBLES=1 instance for the single-nibble build.

module tb_cla_add_scheduler;
   logic        clk;
   logic        rst;
   logic        v0, r0, c0, v1, r1, c1;
   logic [15:0] a0, b0, a1, b1;
   logic        res_valid, res_ready, res_cout, res_id, busy;
   logic [15:0] res_sum;

   logic        n_v0, n_r0, n_c0, n_v1, n_r1, n_c1;
   logic [3:0]  n_a0, n_b0, n_a1, n_b1, n_sum;
   logic        n_rv, n_rr, n_cout, n_id, n_busy;

   int total = 0;
   int bad   = 0;

   cla_add_scheduler #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
      .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_cout(res_cout), .res_id(res_id), .busy(busy)
   );

   cla_add_scheduler #(.NIBBLES(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(n_v0), .req0_ready(n_r0), .req0_a(n_a0), .req0_b(n_b0), .req0_cin(n_c0),
      .req1_valid(n_v1), .req1_ready(n_r1), .req1_a(n_a1), .req1_b(n_b1), .req1_cin(n_c1),
      .res_valid(n_rv), .res_ready(n_rr), .res_sum(n_sum),
      .res_cout(n_cout), .res_id(n_id), .busy(n_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one operation and reports what came back; lat is -1 on timeout.
   task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] sum, output logic cout, output logic rid,
                         output int lat, output bit pulse);
      int n;
      bit got;
      sum = '0; cout = 1'b0; rid = 1'b0; lat = -1; pulse = 1'b0;
      @(posedge clk); #1;
      if (id) begin v1 = 1'b1; a1 = a; b1 = b; c1 = cin; end
      else    begin v0 = 1'b1; a0 = a; b0 = b; c0 = cin; end
      got = 1'b0; n = 0;
      while (!got && n < 50) begin
         @(negedge clk);
         if ((id ? r1 : r0) === 1'b1) got = 1'b1;
         n++;
      end
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      a0 = 16'hDEAD; b0 = 16'hBEEF; a1 = 16'hDEAD; b1 = 16'hBEEF; c0 = 1'b1; c1 = 1'b1;
      if (got) begin
         n = 0;
         while (lat < 0 && n < 50) begin
            @(negedge clk);
            n++;
            if (res_valid === 1'b1) begin
               lat = n; sum = res_sum; cout = res_cout; rid = res_id;
            end
         end
         @(negedge clk);
         pulse = (res_valid === 1'b0);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      v0 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total += 7;
      if (r0 !== 1'b0)        begin bad++; $display("FAIL reset_req0_ready got=%b want=0", r0); end
      if (r1 !== 1'b0)        begin bad++; $display("FAIL reset_req1_ready got=%b want=0", r1); end
      if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
      if (res_sum !== 16'h0)  begin bad++; $display("FAIL reset_res_sum got=%h want=0000", res_sum); end
      if (res_cout !== 1'b0)  begin bad++; $display("FAIL reset_res_cout got=%b want=0", res_cout); end
      if (res_id !== 1'b0)    begin bad++; $display("FAIL reset_res_id got=%b want=0", res_id); end
      if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      v0 = 1'b0;
      rst = 1'b0;
      $display("reset: checked outputs");
   endtask

   task automatic test_basic;
      logic [15:0] s; logic co, id; int lat; bit pulse;
      res_ready = 1'b1;
      run_op(1'b0, 16'h1234, 16'h0FED, 1'b0, s, co, id, lat, pulse);
      total += 5;
      if (s !== 16'h2221) begin bad++; $display("FAIL basic_sum got=%h want=2221", s); end
      if (co !== 1'b0)    begin bad++; $display("FAIL basic_cout got=%b want=0", co); end
      if (id !== 1'b0)    begin bad++; $display("FAIL basic_id got=%b want=0", id); end
      if (lat !== 5)      begin bad++; $display("FAIL basic_latency got=%0d want=5", lat); end
      if (!pulse)         begin bad++; $display("FAIL basic_pulse res_valid still high, want one cycle"); end
      $display("basic: 1234+0FED sum=%h cout=%b id=%b lat=%0d", s, co, id, lat);
   endtask

   task automatic test_carry;
      logic [15:0] s; logic co, id; int lat; bit pulse;
      run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, s, co, id, lat, pulse);
      total += 3;
      if (s !== 16'h0000) begin bad++; $display("FAIL carry_b_sum got=%h want=0000", s); end
      if (co !== 1'b1)    begin bad++; $display("FAIL carry_b_cout got=%b want=1", co); end
      if (id !== 1'b1)    begin bad++; $display("FAIL carry_b_id got=%b want=1", id); end
      $display("carry: FFFF+0001 sum=%h cout=%b id=%b", s, co, id);
      run_op(1'b1, 16'hFFFF, 16'h0000, 1'b1, s, co, id, lat, pulse);
      total += 3;
      if (s !== 16'h0000) begin bad++; $display("FAIL carry_cin_sum got=%h want=0000", s); end
      if (co !== 1'b1)    begin bad++; $display("FAIL carry_cin_cout got=%b want=1", co); end
      if (id !== 1'b1)    begin bad++; $display("FAIL carry_cin_id got=%b want=1", id); end
      $display("carry: FFFF+0000+1 sum=%h cout=%b id=%b", s, co, id);
   endtask

   task automatic test_round_robin;
      int gseq[8]; int gcyc[8]; int rids[8]; logic [15:0] rsums[8]; logic rcout[8];
      int ng, nr; bit both;
      logic [15:0] want_sum; logic want_cout;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      res_ready = 1'b1;
      v0 = 1'b1; a0 = 16'h1111; b0 = 16'h2222; c0 = 1'b0;
      v1 = 1'b1; a1 = 16'h8000; b1 = 16'h8001; c1 = 1'b1;
      ng = 0; nr = 0; both = 1'b0;
      for (int cyc = 0; cyc < 300 && nr < 4; cyc++) begin
         @(negedge clk);
         if (r0 === 1'b1 && r1 === 1'b1) both = 1'b1;
         if ((r0 === 1'b1 || r1 === 1'b1) && ng < 8) begin
            gseq[ng] = (r1 === 1'b1) ? 1 : 0; gcyc[ng] = cyc; ng++;
         end
         if (res_valid === 1'b1) begin
            rids[nr] = int'(res_id); rsums[nr] = res_sum; rcout[nr] = res_cout; nr++;
         end
      end
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      total += 2;
      if (nr !== 4) begin bad++; $display("FAIL rr_results got=%0d want=4", nr); end
      if (both)     begin bad++; $display("FAIL rr_both_ready got=1 want=0"); end
      if (nr == 4 && ng >= 4) begin
         for (int i = 0; i < 4; i++) begin
            want_sum  = (i % 2 == 0) ? 16'h3333 : 16'h0002;
            want_cout = (i % 2 == 0) ? 1'b0 : 1'b1;
            total += 4;
            if (gseq[i] !== i % 2)     begin bad++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", i, gseq[i], i % 2); end
            if (rids[i] !== i % 2)     begin bad++; $display("FAIL rr_res_id[%0d] got=%0d want=%0d", i, rids[i], i % 2); end
            if (rsums[i] !== want_sum) begin bad++; $display("FAIL rr_sum[%0d] got=%h want=%h", i, rsums[i], want_sum); end
            if (rcout[i] !== want_cout) begin bad++; $display("FAIL rr_cout[%0d] got=%b want=%b", i, rcout[i], want_cout); end
            $display("rr: op %0d grant=%0d res_id=%0d sum=%h", i, gseq[i], rids[i], rsums[i]);
         end
         for (int i = 0; i < 3; i++) begin
            total++;
            if (gcyc[i+1] - gcyc[i] !== 6) begin
               bad++; $display("FAIL rr_spacing[%0d] got=%0d want=6", i, gcyc[i+1] - gcyc[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int n; bit got, unstable, stray_ready;
      res_ready = 1'b0;
      @(posedge clk); #1;
      v0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; c0 = 1'b0;
      got = 1'b0; n = 0;
      while (!got && n < 50) begin @(negedge clk); if (r0 === 1'b1) got = 1'b1; n++; end
      @(posedge clk); #1; v0 = 1'b0;
      got = 1'b0; n = 0;
      while (!got && n < 50) begin @(negedge clk); if (res_valid === 1'b1) got = 1'b1; n++; end
      total++;
      if (!got) begin bad++; $display("FAIL bp_result_timeout got=no res_valid want=res_valid"); end
      v1 = 1'b1; a1 = 16'h7777; b1 = 16'h1111; c1 = 1'b0;
      unstable = 1'b0; stray_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_sum !== 16'h0100 || res_cout !== 1'b0 || res_id !== 1'b0) unstable = 1'b1;
         if (r0 !== 1'b0 || r1 !== 1'b0) stray_ready = 1'b1;
      end
      total += 2;
      if (unstable)    begin bad++; $display("FAIL bp_hold got=sum %h valid %b want=sum 0100 valid 1", res_sum, res_valid); end
      if (stray_ready) begin bad++; $display("FAIL bp_ready_in_done got=ready seen want=none"); end
      @(posedge clk); #1; res_ready = 1'b1;
      @(negedge clk);
      total += 2;
      if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_at_handshake got=%b want=1", res_valid); end
      if (r1 !== 1'b0)        begin bad++; $display("FAIL bp_ready_handshake_cycle got=%b want=0", r1); end
      @(negedge clk);
      total += 2;
      if (r1 !== 1'b1)        begin bad++; $display("FAIL bp_accept_after got=%b want=1", r1); end
      if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_cleared got=%b want=0", res_valid); end
      @(posedge clk); #1; v1 = 1'b0; a1 = 16'h0000;
      got = 1'b0; n = 0;
      while (!got && n < 50) begin @(negedge clk); if (res_valid === 1'b1) got = 1'b1; n++; end
      total += 2;
      if (res_sum !== 16'h8888) begin bad++; $display("FAIL bp_second_sum got=%h want=8888", res_sum); end
      if (res_id !== 1'b1)      begin bad++; $display("FAIL bp_second_id got=%b want=1", res_id); end
      $display("backpressure: held 6 cycles, next sum=%h id=%b", res_sum, res_id);
   endtask

   task automatic test_reset_mid_add;
      int n; bit got;
      res_ready = 1'b1;
      @(posedge clk); #1;
      v0 = 1'b1; a0 = 16'h5555; b0 = 16'h2222; c0 = 1'b0;
      got = 1'b0; n = 0;
      while (!got && n < 50) begin @(negedge clk); if (r0 === 1'b1) got = 1'b1; n++; end
      @(posedge clk); #1; v0 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL midadd_busy got=%b want=1", busy); end
      rst = 1'b1;
      #1;
      total += 5;
      if (busy !== 1'b0)      begin bad++; $display("FAIL midadd_rst_busy got=%b want=0", busy); end
      if (res_valid !== 1'b0) begin bad++; $display("FAIL midadd_rst_valid got=%b want=0", res_valid); end
      if (res_sum !== 16'h0)  begin bad++; $display("FAIL midadd_rst_sum got=%h want=0000", res_sum); end
      if (res_cout !== 1'b0)  begin bad++; $display("FAIL midadd_rst_cout got=%b want=0", res_cout); end
      if (res_id !== 1'b0)    begin bad++; $display("FAIL midadd_rst_id got=%b want=0", res_id); end
      #1; rst = 1'b0;
      v0 = 1'b1; a0 = 16'h0102; b0 = 16'h0304; c0 = 1'b0;
      v1 = 1'b1; a1 = 16'h1000; b1 = 16'h1000; c1 = 1'b0;
      @(negedge clk);
      total += 2;
      if (r0 !== 1'b1) begin bad++; $display("FAIL midadd_ptr_r0 got=%b want=1", r0); end
      if (r1 !== 1'b0) begin bad++; $display("FAIL midadd_ptr_r1 got=%b want=0", r1); end
      @(posedge clk); #1; v0 = 1'b0; v1 = 1'b0;
      got = 1'b0; n = 0;
      while (!got && n < 50) begin @(negedge clk); if (res_valid === 1'b1) got = 1'b1; n++; end
      total += 2;
      if (res_sum !== 16'h0406) begin bad++; $display("FAIL midadd_next_sum got=%h want=0406", res_sum); end
      if (res_id !== 1'b0)      begin bad++; $display("FAIL midadd_next_id got=%b want=0", res_id); end
      $display("reset mid-add: next op sum=%h id=%b", res_sum, res_id);
   endtask

   task automatic test_single_nibble;
      int n, lat; bit got;
      n_rr = 1'b1;
      @(posedge clk); #1;
      n_v0 = 1'b1; n_a0 = 4'h9; n_b0 = 4'h8; n_c0 = 1'b1;
      got = 1'b0; n = 0;
      while (!got && n < 50) begin @(negedge clk); if (n_r0 === 1'b1) got = 1'b1; n++; end
      @(posedge clk); #1; n_v0 = 1'b0; n_a0 = 4'h0;
      lat = -1; n = 0;
      while (lat < 0 && n < 50) begin @(negedge clk); n++; if (n_rv === 1'b1) lat = n; end
      total += 4;
      if (lat !== 2)        begin bad++; $display("FAIL n1_latency got=%0d want=2", lat); end
      if (n_sum !== 4'h2)   begin bad++; $display("FAIL n1_sum got=%h want=2", n_sum); end
      if (n_cout !== 1'b1)  begin bad++; $display("FAIL n1_cout got=%b want=1", n_cout); end
      if (n_id !== 1'b0)    begin bad++; $display("FAIL n1_id got=%b want=0", n_id); end
      $display("nibbles=1: 9+8+1 sum=%h cout=%b lat=%0d", n_sum, n_cout, lat);
   endtask

   initial begin
      rst = 1'b1; res_ready = 1'b0;
      v0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0;
      v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
      n_v0 = 1'b0; n_a0 = '0; n_b0 = '0; n_c0 = 1'b0;
      n_v1 = 1'b0; n_a1 = '0; n_b1 = '0; n_c1 = 1'b0;
      n_rr = 1'b0;
      test_reset;
      test_basic;
      test_carry;
      test_round_robin;
      test_backpressure;
      test_reset_mid_add;
      test_single_nibble;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cla_add_scheduler.md
# cla_add_scheduler

Shares one 4-bit carry-lookahead nibble adder between two requesters and sequences it to perform wide additions one nibble per cycle, chaining the carry through a carry register. Sits between two client blocks and the adder datapath. Round-robin arbitration, valid/ready handshakes on both request ports and on the single result port.

## Interface
- NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES; legal range 1..8
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a, req0_b  input  W  requester 0 operands
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1
- res_valid  output  1  result available
- res_ready  input  1  consumer takes result
- res_sum  output  W  sum
- res_cout  output  1  final carry out of nibble NIBBLES-1
- res_id  output  1  requester that owns the result (0/1)
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE: if any reqN_valid, grant one, assert its reqN_ready combinationally in the same cycle, capture a, b, cin, id into operand registers; next state ADD, nibble index k=0, carry register = cin.
- Arbitration: only one valid -> grant it. Both valid -> grant the requester with priority pointer; pointer then points to the other requester. Pointer updates only on a grant. Pointer resets to requester 0.
- Never more than one reqN_ready high; ready is low in ADD and DONE.
- Withdrawing valid before ready is allowed; no grant, no state change.
- ADD: each cycle compute {c, s} = a[4k+3:4k] + b[4k+3:4k] + carry through the nibble adder; write s into sum[4k+3:4k], carry <= c, k <= k+1. After k = NIBBLES-1 go to DONE.
- DONE: res_valid=1; res_sum, res_cout, res_id held stable until res_ready sampled high, then IDLE. No request accepted in DONE, even in the res_ready cycle.
- Arithmetic modulo 2^W; res_cout is the carry out of the top nibble; no overflow flag.
- Reset (any state, including mid-ADD): FSM to IDLE, in-flight operation discarded, pointer to requester 0, all outputs 0.

## Timing
- Reset values: req0_ready=0, req1_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0.
- Accept at edge T (valid & ready high in cycle T-1..T window): ADD occupies NIBBLES cycles; res_valid rises NIBBLES+1 cycles after the accepting edge.
- Result handshake completes on the edge where res_valid & res_ready; earliest next accept is the following cycle in IDLE.
- Max throughput: one operation per NIBBLES+2 cycles with res_ready held high.
- res_* outputs are registered; only reqN_ready and busy may be decoded from state.
- Operand inputs are sampled only at the accepting edge; later changes on req ports have no effect.

## Test plan
- NIBBLES=4, req0 a=0x1234 b=0x0FED cin=0, res_ready=1 -> res_sum=0x2221, res_cout=0, res_id=0, res_valid exactly 5 cycles after accept, single-cycle pulse.
- req1 a=0xFFFF b=0x0001 cin=0 -> res_sum=0x0000, res_cout=1, res_id=1; a=0xFFFF b=0x0000 cin=1 -> same result.
- Both valid continuously after reset, distinct operands -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; never both readys high.
- res_ready held low 6 cycles in DONE -> res_valid, res_sum, res_cout, res_id stable; reqN_ready stays 0 despite pending valid; accept occurs the cycle after res_ready handshake.
- rst pulsed during ADD (k=2) -> all outputs 0 immediately; next operation from req1 with req0 also valid -> req0 granted first (pointer reset).
- NIBBLES=1 build: a=0x9 b=0x8 cin=1 -> res_sum=0x2, res_cout=1, res_valid 2 cycles after accept.
